// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - keypad entry sequencer feeding the add/sub datapath and 7-segment display
module calc_entry_ctrl #(
    parameter int         ALU_LAT = 2,
    parameter logic [3:0] KEY_ADD = 4'hA,
    parameter logic [3:0] KEY_SUB = 4'hB,
    parameter logic [3:0] KEY_CLR = 4'hC,
    parameter logic [3:0] KEY_EQ  = 4'hE
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_value,
    input  logic [3:0] alu_sum,
    input  logic       alu_cout,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_sub,
    output logic       alu_start,
    output logic [3:0] a_char,
    output logic [3:0] b_char,
    output logic [3:0] op_char,
    output logic [3:0] r_char,
    output logic       ovf,
    output logic       busy,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_RES  = 2'd3
    } state_t;

    localparam logic [3:0] LAT = 4'(ALU_LAT);

    state_t     state_q;
    logic [3:0] a_q, b_q, r_q, cnt_q;
    logic       sub_q, ovf_q, start_q;
    logic [3:0] cnt_d;
    logic       key_digit, key_op, key_eq, key_clr;

    assign key_digit = key_valid && (key_value <= 4'd9);
    assign key_op    = key_valid && ((key_value == KEY_ADD) || (key_value == KEY_SUB));
    assign key_eq    = key_valid && (key_value == KEY_EQ);
    assign key_clr   = key_valid && (key_value == KEY_CLR);
    assign cnt_d     = cnt_q - 4'd1;

    always_ff @(posedge clk50M) begin
        // Clear is honoured everywhere except while the datapath is in flight.
        if (rst || (key_clr && (state_q != S_EXEC))) begin
            state_q <= S_A;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            r_q     <= 4'd0;
            sub_q   <= 1'b0;
            ovf_q   <= 1'b0;
            start_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_A: begin
                    if (key_digit) begin
                        a_q <= key_value;
                    end else if (key_op) begin
                        sub_q   <= (key_value == KEY_SUB);
                        b_q     <= 4'd0;
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (key_digit) begin
                        b_q <= key_value;
                    end else if (key_op) begin
                        sub_q <= (key_value == KEY_SUB);
                    end else if (key_eq) begin
                        start_q <= 1'b1;
                        cnt_q   <= LAT;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == 4'd0) begin
                        r_q     <= alu_sum;
                        ovf_q   <= sub_q ? ~alu_cout : alu_cout;
                        state_q <= S_RES;
                    end
                end
                S_RES: begin
                    if (key_digit) begin
                        a_q     <= key_value;
                        b_q     <= 4'd0;
                        r_q     <= 4'd0;
                        ovf_q   <= 1'b0;
                        state_q <= S_A;
                    end else if (key_op) begin
                        a_q     <= r_q;
                        b_q     <= 4'd0;
                        sub_q   <= (key_value == KEY_SUB);
                        ovf_q   <= 1'b0;
                        state_q <= S_B;
                    end
                end
                default: state_q <= S_A;
            endcase
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sub   = sub_q;
    assign alu_start = start_q;
    assign a_char    = a_q;
    assign b_char    = b_q;
    assign op_char   = sub_q ? KEY_SUB : KEY_ADD;
    assign r_char    = r_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q == S_EXEC);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb/tb_calc_entry_ctrl.sv - self-checking bench for calc_entry_ctrl with a latency-accurate ALU stand-in
module tb_calc_entry_ctrl;
    localparam int LAT = 2;

    logic       clk50M = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_value = 4'd0;
    logic [3:0] alu_sum, alu_a, alu_b, a_char, b_char, op_char, r_char;
    logic       alu_cout, alu_sub, alu_start, ovf, busy;
    logic [1:0] state_dbg;

    int checks = 0;
    int failures = 0;

    calc_entry_ctrl #(.ALU_LAT(LAT)) dut (
        .clk50M(clk50M), .rst(rst), .key_valid(key_valid), .key_value(key_value),
        .alu_sum(alu_sum), .alu_cout(alu_cout), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sub(alu_sub), .alu_start(alu_start), .a_char(a_char), .b_char(b_char),
        .op_char(op_char), .r_char(r_char), .ovf(ovf), .busy(busy), .state_dbg(state_dbg)
    );

    always #10 clk50M = ~clk50M;

    // ALU stand-in: true result only in the sampling cycle, inverted garbage otherwise.
    int         cyc = 0;
    logic [4:0] t_res;
    logic       alu_ok;
    always @(posedge clk50M) begin
        if (rst) cyc <= 0;
        else if (alu_start) cyc <= 1;
        else if (cyc != 0 && cyc < 1000) cyc <= cyc + 1;
    end
    assign t_res    = alu_sub ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1) : ({1'b0, alu_a} + {1'b0, alu_b});
    assign alu_ok   = (LAT == 1) ? alu_start : (cyc == LAT - 1);
    assign alu_sum  = alu_ok ? t_res[3:0] : ~t_res[3:0];
    assign alu_cout = alu_ok ? t_res[4] : ~t_res[4];

    int         m_st, m_left;
    logic [3:0] mA, mB, mR, m_res;
    logic       m_sub, m_ovf, m_start, m_rovf;

    task automatic m_reset();
        m_st = 0; m_left = 0; mA = 0; mB = 0; mR = 0; m_res = 0;
        m_sub = 0; m_ovf = 0; m_start = 0; m_rovf = 0;
    endtask

    task automatic m_step(input bit v, input int k);
        m_start = 0;
        if (m_st == 2) begin
            m_left--;
            if (m_left == 0) begin mR = m_res; m_ovf = m_rovf; m_st = 3; end
        end else if (v) begin
            if (k == 12) m_reset();
            else if (k <= 9) begin
                if (m_st == 0) mA = 4'(k);
                else if (m_st == 1) mB = 4'(k);
                else begin mA = 4'(k); mB = 0; mR = 0; m_ovf = 0; m_st = 0; end
            end else if (k == 10 || k == 11) begin
                if (m_st == 3) begin mA = mR; m_ovf = 0; end
                if (m_st != 1) mB = 0;
                m_sub = (k == 11);
                m_st = 1;
            end else if (k == 14 && m_st == 1) begin
                m_st = 2; m_left = LAT; m_start = 1;
                m_res  = m_sub ? 4'(mA - mB) : 4'(mA + mB);
                m_rovf = m_sub ? (mA < mB) : (int'(mA) + int'(mB) > 15);
            end
        end
    endtask

    function automatic logic [29:0] exp_v();
        return {m_start, (m_st == 2), 2'(m_st), mA, mB, (m_sub ? 4'hB : 4'hA), mR, m_ovf, mA, mB, m_sub};
    endfunction

    function automatic logic [29:0] got_v();
        return {alu_start, busy, state_dbg, a_char, b_char, op_char, r_char, ovf, alu_a, alu_b, alu_sub};
    endfunction

    task automatic tick(input bit v, input int k);
        key_valid = v;
        key_value = 4'(k);
        @(posedge clk50M);
        m_step(v, k);
        @(negedge clk50M);
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk50M);
        m_reset();
        @(negedge clk50M);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_char, b_char, r_char, ovf, busy, alu_start, state_dbg, alu_sub} !== 19'd0 || op_char !== 4'hA) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", got_v(), exp_v());
        end
    endtask

    task automatic test_add();
        int ks[] = '{7, 10, 5, 14, -1, -1, -1};
        int busy_n = 0;
        for (int i = 0; i < ks.size(); i++) begin
            tick(ks[i] >= 0, ks[i] < 0 ? 0 : ks[i]);
            busy_n += busy;
            checks++;
            if (got_v() !== exp_v()) begin
                failures++;
                $display("FAIL add step%0d got=%h exp=%h", i, got_v(), exp_v());
            end
        end
        checks++;
        if (r_char !== 4'hC || ovf !== 1'b0 || state_dbg !== 2'd3 || busy_n != LAT) begin
            failures++;
            $display("FAIL add_result got r=%h ovf=%b st=%0d busy=%0d exp r=c ovf=0 st=3 busy=%0d", r_char, ovf, state_dbg, busy_n, LAT);
        end
    endtask

    task automatic test_sub();
        int ks[] = '{3, 11, 5, 14, -1, -1, -1};
        for (int i = 0; i < ks.size(); i++) begin
            tick(ks[i] >= 0, ks[i] < 0 ? 0 : ks[i]);
            checks++;
            if (got_v() !== exp_v()) begin
                failures++;
                $display("FAIL sub step%0d got=%h exp=%h", i, got_v(), exp_v());
            end
        end
        checks++;
        if (r_char !== 4'hE || ovf !== 1'b1) begin
            failures++;
            $display("FAIL sub_result got r=%h ovf=%b exp r=e ovf=1", r_char, ovf);
        end
    endtask

    task automatic test_chain();
        int ks[] = '{9, 10, 9, 14, -1, -1, 11, 1, 14, -1, -1};
        for (int i = 0; i < ks.size(); i++) begin
            tick(ks[i] >= 0, ks[i] < 0 ? 0 : ks[i]);
            checks++;
            if (got_v() !== exp_v()) begin
                failures++;
                $display("FAIL chain step%0d got=%h exp=%h", i, got_v(), exp_v());
            end
            if (i == 6) begin
                checks++;
                if (a_char !== 4'h2 || b_char !== 4'h0 || op_char !== 4'hB || ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL chain_op got a=%h b=%h op=%h ovf=%b exp a=2 b=0 op=b ovf=0", a_char, b_char, op_char, ovf);
                end
            end
        end
        checks++;
        if (r_char !== 4'h1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL chain_result got r=%h ovf=%b exp r=1 ovf=0", r_char, ovf);
        end
    endtask

    task automatic test_exec_keys();
        int ks[] = '{2, 10, 3, 14, 12, 4, -1};
        for (int i = 0; i < ks.size(); i++) begin
            tick(ks[i] >= 0, ks[i] < 0 ? 0 : ks[i]);
            checks++;
            if (got_v() !== exp_v()) begin
                failures++;
                $display("FAIL exec_keys step%0d got=%h exp=%h", i, got_v(), exp_v());
            end
        end
        tick(1, 5); tick(1, 11); tick(1, 1); tick(1, 14);
        rst = 1'b1;
        @(posedge clk50M);
        m_reset();
        @(negedge clk50M);
        rst = 1'b0;
        checks++;
        if (got_v() !== exp_v() || op_char !== 4'hA || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid_exec got=%h exp=%h", got_v(), exp_v());
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0);
            checks++;
            if (alu_start !== 1'b0 || got_v() !== exp_v()) begin
                failures++;
                $display("FAIL rst_idle step%0d got=%h exp=%h", i, got_v(), exp_v());
            end
        end
    endtask

    task automatic test_ignore();
        int ks[] = '{14, 13, 15, 3, 13, 10, 15, 10, 10, 11, 13};
        do_reset();
        for (int i = 0; i < ks.size(); i++) begin
            tick(1, ks[i]);
            checks++;
            if (got_v() !== exp_v()) begin
                failures++;
                $display("FAIL ignore step%0d got=%h exp=%h", i, got_v(), exp_v());
            end
        end
        checks++;
        if (op_char !== 4'hB || state_dbg !== 2'd1 || a_char !== 4'h3) begin
            failures++;
            $display("FAIL ignore_final got op=%h st=%0d a=%h exp op=b st=1 a=3", op_char, state_dbg, a_char);
        end
    endtask

    task automatic test_res_digit_clear();
        int ks[] = '{4, 10, 4, 14, -1, -1, 6};
        for (int i = 0; i < ks.size(); i++) tick(ks[i] >= 0, ks[i] < 0 ? 0 : ks[i]);
        checks++;
        if (a_char !== 4'h6 || b_char !== 4'h0 || r_char !== 4'h0 || ovf !== 1'b0 || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL res_digit got a=%h b=%h r=%h ovf=%b st=%0d exp a=6 b=0 r=0 ovf=0 st=0", a_char, b_char, r_char, ovf, state_dbg);
        end
        tick(1, 11); tick(1, 7); tick(1, 12);
        checks++;
        if ({a_char, b_char, r_char, ovf, busy, state_dbg, alu_sub} !== 17'd0 || op_char !== 4'hA || got_v() !== exp_v()) begin
            failures++;
            $display("FAIL clear_from_b got=%h exp=%h", got_v(), exp_v());
        end
    endtask

    task automatic test_back_to_back();
        int k;
        bit v;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) k = 14;
            tick(v, k);
            checks++;
            if (got_v() !== exp_v()) begin
                failures++;
                $display("FAIL back_to_back step%0d key=%0d v=%0b got=%h exp=%h", i, k, v, got_v(), exp_v());
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_add();
        test_sub();
        test_chain();
        test_exec_keys();
        test_ignore();
        test_res_digit_clear();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
